// File: rtl/reg_file_pkg.sv
// Shared configuration for the rename-tagged architectural register file.
// Optional commit counter is enabled with the REG_FILE_COMMIT_CNT_EN macro.
package reg_file_pkg;

  localparam int RF_ROB_LOG = 4;
  localparam int RF_REG_LOG = 5;
  localparam int RF_DATA_W  = 32;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// Issue query/rename bundle and ROB commit bundle between the pipeline and reg_file.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int ROB_LOG = RF_ROB_LOG,
  parameter int REG_LOG = RF_REG_LOG
);

  logic                 issue_valid;
  logic [REG_LOG-1:0]   issue_dest;
  logic [ROB_LOG-1:0]   issue_RobId;
  logic [REG_LOG-1:0]   issue_rs1;
  logic [REG_LOG-1:0]   issue_rs2;

  logic                 rs1_busy;
  logic [RF_DATA_W-1:0] rs1_value;
  logic [ROB_LOG-1:0]   rs1_RobId;
  logic                 rs2_busy;
  logic [RF_DATA_W-1:0] rs2_value;
  logic [ROB_LOG-1:0]   rs2_RobId;

  logic                 commit_enable;
  logic [REG_LOG-1:0]   commit_index;
  logic [ROB_LOG-1:0]   commit_RobId;
  logic [RF_DATA_W-1:0] commit_value;

  modport master (
    output issue_valid, issue_dest, issue_RobId, issue_rs1, issue_rs2,
    output commit_enable, commit_index, commit_RobId, commit_value,
    input  rs1_busy, rs1_value, rs1_RobId, rs2_busy, rs2_value, rs2_RobId
  );

  modport slave (
    input  issue_valid, issue_dest, issue_RobId, issue_rs1, issue_rs2,
    input  commit_enable, commit_index, commit_RobId, commit_value,
    output rs1_busy, rs1_value, rs1_RobId, rs2_busy, rs2_value, rs2_RobId
  );

endinterface : reg_file_if

// File: rtl/reg_read_port.sv
// One combinational operand read port: r0, commit bypass, in-flight tag, committed value.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_LOG = RF_ROB_LOG,
  parameter int REG_LOG = RF_REG_LOG
) (
  input  logic [REG_LOG-1:0]   i_rs,
  input  logic [RF_DATA_W-1:0] i_value,
  input  logic                 i_busy,
  input  logic [ROB_LOG-1:0]   i_tag,
  input  logic                 i_commit_en,
  input  logic [REG_LOG-1:0]   i_commit_idx,
  input  logic [ROB_LOG-1:0]   i_commit_tag,
  input  logic [RF_DATA_W-1:0] i_commit_value,
  output logic                 o_busy,
  output logic [RF_DATA_W-1:0] o_value,
  output logic [ROB_LOG-1:0]   o_rob_id
);

  logic w_bypass_hit;

  assign w_bypass_hit = i_busy && i_commit_en && (i_commit_idx == i_rs) &&
                        (i_tag == i_commit_tag);

  always_comb begin
    o_busy   = 1'b0;
    o_value  = i_value;
    o_rob_id = i_tag;
    if (i_rs == '0) begin
      o_value = '0;
    end else if (w_bypass_hit) begin
      o_value = i_commit_value;
    end else if (i_busy) begin
      o_busy = 1'b1;
    end
  end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// Architectural register file with rename tags, fed by the ROB commit stream.
// Define REG_FILE_COMMIT_CNT_EN to add the 32-bit commit_count output.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_LOG = RF_ROB_LOG,
  parameter int REG_LOG = RF_REG_LOG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
`ifdef REG_FILE_COMMIT_CNT_EN
  output logic [31:0] commit_count,
`endif
  reg_file_if.slave   bus
);

  localparam int NREG = 2 ** REG_LOG;

  logic [RF_DATA_W-1:0] r_value [NREG];
  logic [ROB_LOG-1:0]   r_tag   [NREG];
  logic [NREG-1:0]      r_busy;

  logic w_commit_wr;
  logic w_issue_wr;
  logic w_commit_clr;
  logic w_bypass_en;

  assign w_commit_wr  = bus.commit_enable && (bus.commit_index != '0);
  assign w_issue_wr   = bus.issue_valid && (bus.issue_dest != '0);
  // A younger rename of the same register (earlier or same-cycle) keeps it busy.
  assign w_commit_clr = w_commit_wr && (r_tag[bus.commit_index] == bus.commit_RobId) &&
                        !(w_issue_wr && (bus.issue_dest == bus.commit_index));
  assign w_bypass_en  = rdy && bus.commit_enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
      r_busy <= '0;
    end else if (rdy) begin
      // Jump commits arrive together with the flush, so the value write is not gated by it.
      if (w_commit_wr) begin
        r_value[bus.commit_index] <= bus.commit_value;
      end
      if (flush) begin
        r_busy <= '0;
      end else begin
        if (w_commit_clr) begin
          r_busy[bus.commit_index] <= 1'b0;
        end
        if (w_issue_wr) begin
          r_busy[bus.issue_dest] <= 1'b1;
          r_tag[bus.issue_dest]  <= bus.issue_RobId;
        end
      end
    end
  end

  reg_read_port #(.ROB_LOG(ROB_LOG), .REG_LOG(REG_LOG)) u_rs1_port (
    .i_rs           (bus.issue_rs1),
    .i_value        (r_value[bus.issue_rs1]),
    .i_busy         (r_busy[bus.issue_rs1]),
    .i_tag          (r_tag[bus.issue_rs1]),
    .i_commit_en    (w_bypass_en),
    .i_commit_idx   (bus.commit_index),
    .i_commit_tag   (bus.commit_RobId),
    .i_commit_value (bus.commit_value),
    .o_busy         (bus.rs1_busy),
    .o_value        (bus.rs1_value),
    .o_rob_id       (bus.rs1_RobId)
  );

  reg_read_port #(.ROB_LOG(ROB_LOG), .REG_LOG(REG_LOG)) u_rs2_port (
    .i_rs           (bus.issue_rs2),
    .i_value        (r_value[bus.issue_rs2]),
    .i_busy         (r_busy[bus.issue_rs2]),
    .i_tag          (r_tag[bus.issue_rs2]),
    .i_commit_en    (w_bypass_en),
    .i_commit_idx   (bus.commit_index),
    .i_commit_tag   (bus.commit_RobId),
    .i_commit_value (bus.commit_value),
    .o_busy         (bus.rs2_busy),
    .o_value        (bus.rs2_value),
    .o_rob_id       (bus.rs2_RobId)
  );

`ifdef REG_FILE_COMMIT_CNT_EN
  logic [31:0] r_commit_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_count <= '0;
    end else if (rdy && w_commit_wr) begin
      r_commit_count <= r_commit_count + 32'd1;
    end
  end

  assign commit_count = r_commit_count;
`endif

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, rename/bypass, flush, rdy and r0 cases.
module tb_reg_file;

  logic clk;
  logic rst;
  logic rdy;
  logic flush;
  int   n_pass;
  int   n_total;
  int   exp_cnt;

  reg_file_if bus ();

`ifdef REG_FILE_COMMIT_CNT_EN
  logic [31:0] commit_count;
`endif

  reg_file dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
`ifdef REG_FILE_COMMIT_CNT_EN
    .commit_count (commit_count),
`endif
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flush             = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_dest    = '0;
    bus.issue_RobId   = '0;
    bus.commit_enable = 1'b0;
    bus.commit_index  = '0;
    bus.commit_RobId  = '0;
    bus.commit_value  = '0;
  endtask

  // Advances one clock; inputs are changed 1 ns after the edge and checked 2 ns later.
  task automatic tick();
    if (!rst && rdy && bus.commit_enable && bus.commit_index != 5'd0) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] dest, input logic [3:0] tag);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = dest;
    bus.issue_RobId = tag;
  endtask

  task automatic commit(input logic [4:0] idx, input logic [3:0] tag, input logic [31:0] val);
    bus.commit_enable = 1'b1;
    bus.commit_index  = idx;
    bus.commit_RobId  = tag;
    bus.commit_value  = val;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    bus.issue_rs1 = 5'd0;
    bus.issue_rs2 = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    bus.issue_rs1 = 5'd5;
    bus.issue_rs2 = 5'd0;
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value, bus.rs1_RobId} !== 37'h0)
      $display("FAIL reset_rs1 got=%h exp=%h", {bus.rs1_busy, bus.rs1_value, bus.rs1_RobId}, 37'h0);
    else n_pass++;
    n_total++;
    if ({bus.rs2_busy, bus.rs2_value, bus.rs2_RobId} !== 37'h0)
      $display("FAIL reset_rs2 got=%h exp=%h", {bus.rs2_busy, bus.rs2_value, bus.rs2_RobId}, 37'h0);
    else n_pass++;
  endtask

  task automatic test_issue_bypass();
    issue(5'd3, 4'd7);
    tick();
    idle();
    bus.issue_rs1 = 5'd3;
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_RobId} !== {1'b1, 4'd7})
      $display("FAIL issue_busy got=%b/%0d exp=1/7", bus.rs1_busy, bus.rs1_RobId);
    else n_pass++;
    commit(5'd3, 4'd7, 32'hDEADBEEF);
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL commit_bypass got=%b/%h exp=0/deadbeef", bus.rs1_busy, bus.rs1_value);
    else n_pass++;
    tick();
    idle();
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL commit_stored got=%b/%h exp=0/deadbeef", bus.rs1_busy, bus.rs1_value);
    else n_pass++;
  endtask

  task automatic test_younger_rename();
    issue(5'd4, 4'd2);
    tick();
    issue(5'd4, 4'd5);
    tick();
    idle();
    commit(5'd4, 4'd2, 32'd11);
    bus.issue_rs2 = 5'd4;
    #2;
    n_total++;
    if ({bus.rs2_busy, bus.rs2_RobId} !== {1'b1, 4'd5})
      $display("FAIL stale_commit_no_bypass got=%b/%0d exp=1/5", bus.rs2_busy, bus.rs2_RobId);
    else n_pass++;
    tick();
    idle();
    bus.issue_rs1 = 5'd4;
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_RobId} !== {1'b1, 4'd5})
      $display("FAIL stale_commit_keeps_busy got=%b/%0d exp=1/5", bus.rs1_busy, bus.rs1_RobId);
    else n_pass++;
    commit(5'd4, 4'd5, 32'd22);
    tick();
    idle();
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'd22})
      $display("FAIL young_commit got=%b/%0d exp=0/22", bus.rs1_busy, bus.rs1_value);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    issue(5'd6, 4'd1);
    tick();
    idle();
    commit(5'd6, 4'd1, 32'd9);
    issue(5'd6, 4'd3);
    bus.issue_rs1 = 5'd6;
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'd9})
      $display("FAIL same_cycle_bypass got=%b/%0d exp=0/9", bus.rs1_busy, bus.rs1_value);
    else n_pass++;
    tick();
    idle();
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_RobId} !== {1'b1, 4'd3})
      $display("FAIL same_cycle_issue_wins got=%b/%0d exp=1/3", bus.rs1_busy, bus.rs1_RobId);
    else n_pass++;
  endtask

  task automatic test_flush();
    commit(5'd9, 4'd0, 32'h55);
    tick();
    idle();
    issue(5'd8, 4'd4);
    tick();
    issue(5'd9, 4'd6);
    tick();
    idle();
    flush = 1'b1;
    commit(5'd8, 4'd4, 32'h100);
    issue(5'd11, 4'd2);
    tick();
    idle();
    bus.issue_rs1 = 5'd8;
    bus.issue_rs2 = 5'd9;
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h100})
      $display("FAIL flush_commit got=%b/%h exp=0/100", bus.rs1_busy, bus.rs1_value);
    else n_pass++;
    n_total++;
    if ({bus.rs2_busy, bus.rs2_value, bus.rs2_RobId} !== {1'b0, 32'h55, 4'd6})
      $display("FAIL flush_clears_busy got=%b/%h/%0d exp=0/55/6", bus.rs2_busy, bus.rs2_value, bus.rs2_RobId);
    else n_pass++;
    bus.issue_rs1 = 5'd11;
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value, bus.rs1_RobId} !== {1'b0, 32'h0, 4'd0})
      $display("FAIL flush_drops_issue got=%b/%h/%0d exp=0/0/0", bus.rs1_busy, bus.rs1_value, bus.rs1_RobId);
    else n_pass++;
  endtask

  task automatic test_rdy_low();
    issue(5'd10, 4'd9);
    tick();
    idle();
    rdy = 1'b0;
    commit(5'd10, 4'd9, 32'h77);
    issue(5'd10, 4'd3);
    bus.issue_rs1 = 5'd10;
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_RobId} !== {1'b1, 4'd9})
      $display("FAIL rdy_low_no_bypass got=%b/%0d exp=1/9", bus.rs1_busy, bus.rs1_RobId);
    else n_pass++;
    tick();
    idle();
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_RobId} !== {1'b1, 4'd9})
      $display("FAIL rdy_low_hold got=%b/%0d exp=1/9", bus.rs1_busy, bus.rs1_RobId);
    else n_pass++;
    rdy = 1'b1;
    flush = 1'b1;
    tick();
    idle();
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value, bus.rs1_RobId} !== {1'b0, 32'h0, 4'd9})
      $display("FAIL rdy_low_no_write got=%b/%h/%0d exp=0/0/9", bus.rs1_busy, bus.rs1_value, bus.rs1_RobId);
    else n_pass++;
  endtask

  task automatic test_r0();
    issue(5'd0, 4'd5);
    commit(5'd0, 4'd0, 32'hFFFF);
    bus.issue_rs1 = 5'd0;
    bus.issue_rs2 = 5'd0;
    #2;
    n_total++;
    if ({bus.rs1_busy, bus.rs1_value} !== 33'h0)
      $display("FAIL r0_same_cycle got=%b/%h exp=0/0", bus.rs1_busy, bus.rs1_value);
    else n_pass++;
    tick();
    idle();
    #2;
    n_total++;
    if ({bus.rs2_busy, bus.rs2_value} !== 33'h0)
      $display("FAIL r0_after_write got=%b/%h exp=0/0", bus.rs2_busy, bus.rs2_value);
    else n_pass++;
  endtask

`ifdef REG_FILE_COMMIT_CNT_EN
  task automatic test_commit_count();
    #2;
    n_total++;
    if (commit_count !== 32'(exp_cnt))
      $display("FAIL commit_count got=%0d exp=%0d", commit_count, exp_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    exp_cnt = 0;
    bus.issue_rs1 = '0;
    bus.issue_rs2 = '0;
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    #1;
    test_reset();
    test_issue_bypass();
    test_younger_rename();
    test_same_cycle();
    test_flush();
    test_rdy_low();
    test_r0();
`ifdef REG_FILE_COMMIT_CNT_EN
    test_commit_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_file
